switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Upstream stage for the relay model. It conditions a raw, bouncy mechanical-switch input into a clean level that drives the relay's `switch` input.
- Internally it is a 2-flop synchroniser, a 4-state debounce FSM and a stability counter.
- Outputs are the debounced level plus one-cycle edge pulses, so later stages such as relay chains and counters can step on each press.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before the output changes. Legal range is 2 to 2^CNT_W-1.
- CNT_W, 8: width of the stability counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- raw_switch  input  1  asynchronous bouncy switch contact
- switch  output  1  debounced level; connects to the relay `switch` input
- rise  output  1  one-cycle pulse when `switch` goes 0->1
- fall  output  1  one-cycle pulse when `switch` goes 1->0
- busy  output  1  high while a candidate transition is being qualified

Behaviour:
- Reset (asynchronous assert, any time): sync flops=0, cnt=0, state=LOW, switch=0, rise=0, fall=0, busy=0. The block ignores raw_switch until rst deasserts.
- Synchroniser: raw_switch -> s1 -> s2, both reset to 0. The FSM sees only s2.
- FSM states:
  - LOW:
    - s2=1 -> WAIT_HIGH, cnt=1.
    - Otherwise stay.
  - WAIT_HIGH:
    - s2=0 -> LOW, cnt=0 (abort, no output change).
    - s2=1 and cnt==STABLE_CYCLES-1 -> HIGH, switch=1, rise=1.
    - s2=1 otherwise -> cnt=cnt+1.
  - HIGH:
    - s2=0 -> WAIT_LOW, cnt=1.
    - Otherwise stay.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - s2=1 -> HIGH (abort).
    - s2=0 and cnt==STABLE_CYCLES-1 -> LOW, switch=0, fall=1.
- Outputs:
  - All outputs are registered.
  - rise and fall are high for exactly one cycle and are never both high.
  - busy = (state is WAIT_HIGH or WAIT_LOW), registered with the state.
- Latency: raw_switch changes before edge 0 and stays stable. `switch` then updates on edge STABLE_CYCLES+1, i.e. the (STABLE_CYCLES+2)th edge: 2 sync edges plus STABLE_CYCLES qualifying samples.
- Boundary conditions:
  - Glitch shorter than STABLE_CYCLES samples: switch, rise and fall are unchanged; only busy toggles.
  - Reversal on the final qualifying edge: s2 is sampled opposite, so the FSM aborts and the output does not change.
  - Reset mid-qualification: the pending transition is discarded. If raw_switch is high at release, the full latency applies again from LOW.
  - Continuous bounce faster than STABLE_CYCLES: the FSM alternates between LOW and WAIT_HIGH (or HIGH and WAIT_LOW) indefinitely, and `switch` holds its last value.
  - cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
  - A STABLE_CYCLES value outside the legal range is rejected by an elaboration-time check.

Decomposition:
- Shared package relay_pkg holds:
  - the state encoding constants (LOW=2'b00, WAIT_HIGH=2'b01, HIGH=2'b11, WAIT_LOW=2'b10);
  - the default STABLE_CYCLES;
  - the default CNT_W.
- One sub-module, sync_2ff: 2-flop synchroniser with clk/rst, 1-bit d/q, reset value 0. It is reused by later blocks taking asynchronous inputs.

Test Plan (STABLE_CYCLES=4):
1. Reset with raw_switch=0, then set raw_switch=1 before edge 0 and hold -> switch=1 and rise=1 after edge 5; rise=0 after edge 6; busy high after edges 2-4.
2. From HIGH, pulse raw_switch=0 for 2 cycles -> switch stays 1, fall never asserts, busy asserts then clears.
3. Bounce raw_switch 1,0,1,0,1 on successive cycles, then hold 1 -> exactly one rise pulse, issued 6 edges after the final 0->1 transition; no fall pulse.
4. Assert rst asynchronously mid-WAIT_HIGH (between edges) -> switch, rise, fall, busy and state go to 0/LOW immediately, without waiting for a clock. With raw_switch held 1, switch rises 6 edges after reset release.
5. Full press then release, each held 10 cycles -> switch high for exactly 10 cycles; one rise and one fall pulse, each one cycle wide.
6. Connect switch to the relay model with batt=1 -> relay output c follows the debounced switch with no bounce transitions.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared definitions for the relay model front end: debounce FSM state encoding
// and default debounce parameters.
package relay_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b11,
    WAIT_LOW  = 2'b10
  } db_state_e;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both stages clear to 0
// on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/switch_debouncer.sv
// Conditions a bouncy mechanical switch into a clean level plus one-cycle
// rise/fall pulses; a level change must hold for STABLE_CYCLES samples to count.
module switch_debouncer
  import relay_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_switch,
  output logic switch,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > ((64'sd1 <<< CNT_W) - 64'sd1)) begin : g_bad_stable_cycles
    $error("switch_debouncer: STABLE_CYCLES=%0d outside 2..2^CNT_W-1", STABLE_CYCLES);
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       s2;
  db_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       switch_q, switch_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       busy_q, busy_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_switch),
    .q   (s2)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    switch_d = switch_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HIGH;
          cnt_d    = '0;
          switch_d = 1'b1;
          rise_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = LOW;
          cnt_d    = '0;
          switch_d = 1'b0;
          fall_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = LOW;
        cnt_d    = '0;
        switch_d = 1'b0;
      end
    endcase
    // busy reflects the state being entered so it lines up with state_q
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOW;
      cnt_q    <= '0;
      switch_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      switch_q <= switch_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
    end
  end

  assign switch = switch_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4: latency, glitch
// rejection, bounce, asynchronous reset and press/release pulse widths.
module tb_switch_debouncer;

  logic clk;
  logic rst;
  logic raw_switch;
  logic switch;
  logic rise;
  logic fall;
  logic busy;

  int n_checks = 0;
  int n_pass   = 0;

  switch_debouncer #(
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_switch (raw_switch),
    .switch     (switch),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pat[5];
    int hi_cyc, n_rise, n_fall, rise_at, fall_at, toggles;
    logic last_sw;
    pat = '{1, 0, 1, 0, 1};

    // reset state
    rst = 1'b1;
    raw_switch = 1'b0;
    repeat (3) step();
    check("rst_switch", int'(switch), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_busy", int'(busy), 0);
    #2 rst = 1'b0;
    step();
    step();
    check("idle_switch", int'(switch), 0);
    check("idle_busy", int'(busy), 0);

    // test 1: clean press, latency
    raw_switch = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      check($sformatf("t1_switch_e%0d", e), int'(switch), int'(e >= 5));
      check($sformatf("t1_rise_e%0d", e), int'(rise), int'(e == 5));
      check($sformatf("t1_busy_e%0d", e), int'(busy), int'(e >= 2 && e <= 4));
      check($sformatf("t1_fall_e%0d", e), int'(fall), 0);
    end

    // test 2: 2-cycle low glitch while HIGH
    raw_switch = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      if (e == 2) raw_switch = 1'b1;
      step();
      check($sformatf("t2_switch_e%0d", e), int'(switch), 1);
      check($sformatf("t2_fall_e%0d", e), int'(fall), 0);
      check($sformatf("t2_busy_e%0d", e), int'(busy), int'(e == 2 || e == 3));
    end

    // release back to LOW
    raw_switch = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      step();
      check($sformatf("rel_fall_e%0d", e), int'(fall), int'(e == 5));
      check($sformatf("rel_switch_e%0d", e), int'(switch), int'(e < 5));
    end

    // test 3: bounce 1,0,1,0,1 then hold 1
    for (int e = 0; e <= 12; e++) begin
      raw_switch = (e < 5) ? pat[e][0] : 1'b1;
      step();
      check($sformatf("t3_rise_e%0d", e), int'(rise), int'(e == 9));
      check($sformatf("t3_fall_e%0d", e), int'(fall), 0);
      check($sformatf("t3_switch_e%0d", e), int'(switch), int'(e >= 9));
    end

    // test 4: asynchronous reset from HIGH, then mid-WAIT_HIGH
    #2 rst = 1'b1;
    #1;
    check("t4a_switch", int'(switch), 0);
    check("t4a_rise", int'(rise), 0);
    check("t4a_busy", int'(busy), 0);
    #1 rst = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      step();
      check($sformatf("t4b_busy_e%0d", e), int'(busy), int'(e >= 2));
    end
    #2 rst = 1'b1;
    #1;
    check("t4c_busy", int'(busy), 0);
    check("t4c_switch", int'(switch), 0);
    check("t4c_fall", int'(fall), 0);
    #1 rst = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      step();
      check($sformatf("t4d_rise_e%0d", e), int'(rise), int'(e == 5));
      check($sformatf("t4d_switch_e%0d", e), int'(switch), int'(e >= 5));
      check($sformatf("t4d_busy_e%0d", e), int'(busy), int'(e >= 2 && e <= 4));
    end

    // test 5: press 10 cycles, release, pulse widths
    raw_switch = 1'b0;
    repeat (12) step();
    check("t5_pre_switch", int'(switch), 0);
    hi_cyc = 0; n_rise = 0; n_fall = 0; rise_at = -1; fall_at = -1; toggles = 0;
    last_sw = switch;
    raw_switch = 1'b1;
    for (int e = 0; e <= 29; e++) begin
      if (e == 10) raw_switch = 1'b0;
      step();
      if (switch) hi_cyc++;
      if (switch != last_sw) toggles++;
      last_sw = switch;
      if (rise) begin n_rise++; rise_at = e; end
      if (fall) begin n_fall++; fall_at = e; end
    end
    check("t5_high_cycles", hi_cyc, 10);
    check("t5_rise_cycles", n_rise, 1);
    check("t5_fall_cycles", n_fall, 1);
    check("t5_rise_edge", rise_at, 5);
    check("t5_fall_edge", fall_at, 15);
    check("t5_switch_toggles", toggles, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
